// File: rtl/memoria_responder_if.sv
// memoria_responder_if: request/response bus between a requester and the memory responder
interface memoria_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              memWriteOrRead;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              ready;
    logic              err;
    logic              busy;
    logic [1:0]        estado;

    modport master (
        output req, memWriteOrRead, address, datain,
        input  dataout, ready, err, busy, estado
    );

    modport slave (
        input  req, memWriteOrRead, address, datain,
        output dataout, ready, err, busy, estado
    );
endinterface

// File: rtl/memoria_responder.sv
// memoria_responder: word-organised memory with one read wait state and a one-cycle ready pulse
module memoria_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256
) (
    input logic                clk,
    input logic                reset,
    memoria_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        READ_DATA = 2'd2,
        WRITE_ACK = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_dataout;
    logic [IDX_W-1:0]  r_idx;
    logic              r_mis;
    logic [IDX_W-1:0]  w_idx;
    logic              w_mis;
    logic              w_accept;
    logic              w_ready;
    logic              w_unused;

    // Upper address bits are deliberately dropped so the array aliases.
    assign w_idx    = bus.address[IDX_W+1:2];
    assign w_mis    = bus.address[1:0] != 2'b00;
    assign w_unused = ^bus.address[ADDR_W-1:IDX_W+2];
    assign w_accept = (r_state == IDLE) && bus.req;
    assign w_ready  = (r_state == READ_DATA) || (r_state == WRITE_ACK);

    // Next-state: requests are only looked at in IDLE, everything else walks back to IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      w_next = bus.req ? (bus.memWriteOrRead ? WRITE_ACK : READ_WAIT) : IDLE;
            READ_WAIT: w_next = READ_DATA;
            default:   w_next = IDLE;
        endcase
    end

    // State, latched request and the read data register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_mis     <= 1'b0;
            r_dataout <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx <= w_idx;
                r_mis <= w_mis;
            end
            if (r_state == READ_WAIT)
                r_dataout <= r_mis ? '0 : r_mem[r_idx];
        end
    end

    // Aligned writes commit on the accepting edge so a following read sees the new word.
    always_ff @(posedge clk) begin
        if (w_accept && bus.memWriteOrRead && !w_mis)
            r_mem[w_idx] <= bus.datain;
    end

    assign bus.dataout = r_dataout;
    assign bus.ready   = w_ready;
    assign bus.err     = w_ready && r_mis;
    assign bus.busy    = r_state != IDLE;
    assign bus.estado  = r_state;
endmodule

// File: tb/tb_memoria_responder.sv
// tb_memoria_responder: directed vector table plus hand sequences for busy, reset and back-to-back corners
module tb_memoria_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    memoria_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memoria_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [13];

    localparam logic [1:0] CONT_EST [10] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req            = r;
        bus.memWriteOrRead = we;
        bus.address        = a;
        bus.datain         = d;
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_do);
        int lat;
        @(negedge clk);
        drive(1'b1, we, a, d);
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        if (!we) chk("read_wait_state", 32'(bus.estado), 32'd1);
        while (!bus.ready && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, we ? 32'd1 : 32'd2);
        chk("ack_state", 32'(bus.estado), we ? 32'd3 : 32'd2);
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("dataout", bus.dataout, exp_do);
        @(negedge clk);
        chk("ready_drop", 32'(bus.ready), 32'd0);
        chk("back_idle", 32'(bus.estado), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h1234_5678};
        vecs[5]  = '{1'b1, 32'h0000_0002, 32'hAAAA_5555, 1'b1, 32'h1234_5678};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_F00D};
        vecs[7]  = '{1'b0, 32'h0000_0003, 32'h0,         1'b1, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 32'h0000_03FC, 32'h55AA_55AA, 1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h55AA_55AA};
        vecs[12] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h55AA_55AA};

        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_estado", 32'(bus.estado), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_dataout", bus.dataout, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            txn(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].e, vecs[i].q);

        // Request held and retargeted while busy must be ignored, not queued.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_0010, 32'h9999_9999);
        chk("ign_wait", 32'(bus.estado), 32'd1);
        @(negedge clk);
        chk("ign_ready", 32'(bus.ready), 32'd1);
        chk("ign_data", bus.dataout, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ign_no_pulse", 32'(bus.ready), 32'd0);
            chk("ign_idle", 32'(bus.estado), 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Reset during READ_WAIT aborts the read at once.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        bus.req = 1'b0;
        chk("rr_wait", 32'(bus.estado), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rr_busy", 32'(bus.busy), 32'd0);
        chk("rr_estado", 32'(bus.estado), 32'd0);
        chk("rr_dataout", bus.dataout, 32'd0);
        chk("rr_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rr_no_pulse", 32'(bus.ready), 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1111_1111);

        // Reset during WRITE_ACK loses the pulse but keeps the committed write.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_0024, 32'h7777_7777);
        @(negedge clk);
        bus.req = 1'b0;
        chk("rw_ack", 32'(bus.estado), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("rw_ready", 32'(bus.ready), 32'd0);
        chk("rw_err", 32'(bus.err), 32'd0);
        chk("rw_dataout", bus.dataout, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txn(1'b0, 32'h0000_0024, 32'h0, 1'b0, 32'h7777_7777);

        // req held high with alternating ops: accepted only from IDLE.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("cont_estado", 32'(bus.estado), 32'(CONT_EST[c]));
            chk("cont_ready", 32'(bus.ready), 32'(CONT_EST[c] == 2'd2 || CONT_EST[c] == 2'd3));
            chk("cont_busy", 32'(bus.busy), 32'(CONT_EST[c] != 2'd0));
            if (c == 1) chk("cont_rd0", bus.dataout, 32'hDEAD_BEEF);
            if (c == 6) chk("cont_rd1", bus.dataout, 32'h3030_3030);
            if (c == 0) drive(1'b1, 1'b1, 32'h0000_0030, 32'h3030_3030);
            if (c == 3) drive(1'b1, 1'b0, 32'h0000_0030, 32'h0);
            if (c == 5) drive(1'b1, 1'b1, 32'h0000_0010, 32'h1010_1010);
            if (c == 8) bus.req = 1'b0;
        end
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h1010_1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
